// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - LC-3b opcode, ALU op and pipelined control word types
package lc3b_types;

  typedef enum logic [3:0] {
    op_br   = 4'd0,
    op_add  = 4'd1,
    op_ldb  = 4'd2,
    op_stb  = 4'd3,
    op_jsr  = 4'd4,
    op_and  = 4'd5,
    op_ldr  = 4'd6,
    op_str  = 4'd7,
    op_rti  = 4'd8,
    op_not  = 4'd9,
    op_ldi  = 4'd10,
    op_sti  = 4'd11,
    op_jmp  = 4'd12,
    op_shf  = 4'd13,
    op_lea  = 4'd14,
    op_trap = 4'd15
  } lc3b_opcode;

  // alu_add is encoding 0 so an all-zero word decodes as a plain add.
  typedef enum logic [2:0] {
    alu_add  = 3'd0,
    alu_and  = 3'd1,
    alu_not  = 3'd2,
    alu_xor  = 3'd3,
    alu_shf  = 3'd4,
    alu_pass = 3'd5
  } lc3b_aluop;

  typedef struct packed {
    lc3b_opcode opcode;
    lc3b_aluop  aluop;
    logic       load_regfile;
    logic       mem_read;
    logic       mem_write;
    logic       br_en;
    logic       illegal;
  } lc3b_control_word;

  typedef struct packed {
    logic             valid;
    lc3b_control_word ctrl;
  } ctrl_stage_t;

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational LC-3b opcode to control word decode
module ctrl_decode
  import lc3b_types::*;
#(
  parameter logic [15:0] OPCODE_EN = 16'hFEFF
) (
  input  logic [15:0]      instr,
  output lc3b_control_word ctrl
);

  lc3b_opcode op;
  logic       unused_operands;

  assign op              = lc3b_opcode'(instr[15:12]);
  assign unused_operands = ^instr[11:0];

  always_comb begin
    ctrl        = '0;
    ctrl.opcode = op;
    if (!OPCODE_EN[instr[15:12]]) begin
      ctrl.illegal = 1'b1;
    end else begin
      ctrl.aluop = alu_pass;
      case (op)
        op_add: begin ctrl.aluop = alu_add; ctrl.load_regfile = 1'b1; end
        op_and: begin ctrl.aluop = alu_and; ctrl.load_regfile = 1'b1; end
        op_not: begin ctrl.aluop = alu_not; ctrl.load_regfile = 1'b1; end
        op_ldr, op_ldb, op_ldi: begin
          ctrl.aluop        = alu_add;
          ctrl.mem_read     = 1'b1;
          ctrl.load_regfile = 1'b1;
        end
        op_str, op_stb, op_sti: begin
          ctrl.aluop     = alu_add;
          ctrl.mem_write = 1'b1;
        end
        op_br:   ctrl.br_en = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ctrl_pipeline.sv
// rtl/ctrl_pipeline.sv - decoded control word pipeline with stall, flush and counters
// Optional perf counters: CTRL_PIPELINE_PERF_EN
module ctrl_pipeline
  import lc3b_types::*;
#(
  parameter int          NUM_STAGES = 4,
  parameter logic [15:0] OPCODE_EN  = 16'hFEFF,
  parameter int          CNT_W      = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  instr_valid,
  input  logic [15:0]                           instr,
  output logic                                  instr_ready,
  input  logic                                  stall_en,
  input  logic [$clog2(NUM_STAGES)-1:0]         stall_stage,
  input  logic [NUM_STAGES-1:0]                 flush_mask,
  output logic [NUM_STAGES-1:0]                 stage_valid,
  output lc3b_control_word [NUM_STAGES-1:0]     stage_ctrl,
  output logic [CNT_W-1:0]                      illegal_count,
  output logic [CNT_W-1:0]                      stall_cycles,
  output logic [CNT_W-1:0]                      bubble_count
);

  lc3b_control_word               dec_word;
  ctrl_stage_t [NUM_STAGES-1:0]   stage_q;
  ctrl_stage_t [NUM_STAGES-1:0]   nxt;
  logic        [NUM_STAGES-1:0]   veff;
  logic                           accept;
  int                             s;

  ctrl_decode #(.OPCODE_EN(OPCODE_EN)) u_decode (
    .instr (instr),
    .ctrl  (dec_word)
  );

  assign instr_ready = rst_n & ~stall_en;
  assign accept      = instr_valid & instr_ready;
  assign s           = int'(stall_stage);

  always_comb begin
    for (int k = 0; k < NUM_STAGES; k++) begin
      stage_valid[k] = stage_q[k].valid;
      stage_ctrl[k]  = stage_q[k].ctrl;
    end
  end

  // Flushed entries stay in place but can never move downstream as valid.
  assign veff = stage_valid & ~flush_mask;

  always_comb begin
    nxt[0].valid = accept;
    nxt[0].ctrl  = accept ? dec_word : '0;
    for (int k = 1; k < NUM_STAGES; k++) begin
      nxt[k].valid = veff[k-1];
      nxt[k].ctrl  = stage_q[k-1].ctrl;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        if (stall_en && k <= s) begin
          stage_q[k].valid <= veff[k];
        end else if (stall_en && k == s + 1) begin
          stage_q[k] <= '0;
        end else begin
          stage_q[k] <= nxt[k];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      illegal_count <= '0;
    end else if (accept && dec_word.illegal && illegal_count != '1) begin
      illegal_count <= illegal_count + 1'b1;
    end
  end

`ifdef CTRL_PIPELINE_PERF_EN
  logic             bubble_ins;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] bubble_q;

  // A full-depth stall freezes everything, so it is the only stall with no bubble.
  assign bubble_ins = stall_en ? (s != NUM_STAGES - 1) : !accept;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (stall_en && stall_q != '1)    stall_q  <= stall_q + 1'b1;
      if (bubble_ins && bubble_q != '1) bubble_q <= bubble_q + 1'b1;
    end
  end

  assign stall_cycles = stall_q;
  assign bubble_count = bubble_q;
`else
  assign stall_cycles = '0;
  assign bubble_count = '0;
`endif

endmodule

// File: tb/tb_ctrl_pipeline.sv
// tb/tb_ctrl_pipeline.sv - directed self-checking bench for ctrl_pipeline
module tb_ctrl_pipeline;
  import lc3b_types::*;

  logic                   clk;
  logic                   rst_n;
  logic                   instr_valid;
  logic [15:0]            instr;
  logic                   instr_ready;
  logic                   stall_en;
  logic [1:0]             stall_stage;
  logic [3:0]             flush_mask;
  logic [3:0]             stage_valid;
  lc3b_control_word [3:0] stage_ctrl;
  logic [15:0]            illegal_count;
  logic [15:0]            stall_cycles;
  logic [15:0]            bubble_count;

  logic                   sat_ready;
  logic [3:0]             sat_valid;
  lc3b_control_word [3:0] sat_ctrl;
  logic [1:0]             sat_illegal;
  logic [1:0]             sat_stall;
  logic [1:0]             sat_bubble;

  int errors = 0;
  int checks = 0;
  logic [31:0] bc_snap;
  logic [31:0] sc_snap;

  ctrl_pipeline #(.NUM_STAGES(4), .OPCODE_EN(16'hFEFF), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .stall_en(stall_en), .stall_stage(stall_stage),
    .flush_mask(flush_mask), .stage_valid(stage_valid), .stage_ctrl(stage_ctrl),
    .illegal_count(illegal_count), .stall_cycles(stall_cycles), .bubble_count(bubble_count)
  );

  // Narrow-counter copy used only to reach saturation in a few accepts.
  ctrl_pipeline #(.NUM_STAGES(4), .OPCODE_EN(16'hFEFF), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(sat_ready), .stall_en(stall_en), .stall_stage(stall_stage),
    .flush_mask(flush_mask), .stage_valid(sat_valid), .stage_ctrl(sat_ctrl),
    .illegal_count(sat_illegal), .stall_cycles(sat_stall), .bubble_count(sat_bubble)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] w(input lc3b_opcode op, input lc3b_aluop a,
                                    input logic lr, input logic mr, input logic mw,
                                    input logic br, input logic il);
    lc3b_control_word c;
    c.opcode = op; c.aluop = a; c.load_regfile = lr; c.mem_read = mr;
    c.mem_write = mw; c.br_en = br; c.illegal = il;
    return 32'(c);
  endfunction

  function automatic logic [31:0] perf(input logic [31:0] v);
`ifdef CTRL_PIPELINE_PERF_EN
    return v;
`else
    return 32'(v & 32'h0);
`endif
  endfunction

  task automatic cyc(input logic v, input logic [15:0] i, input logic st,
                     input logic [1:0] ss, input logic [3:0] fm);
    instr_valid = v; instr = i; stall_en = st; stall_stage = ss; flush_mask = fm;
    @(posedge clk);
    #1;
  endtask

  localparam logic [15:0] I_ADD = 16'h1042;
  localparam logic [15:0] I_AND = 16'h5042;
  localparam logic [15:0] I_LDR = 16'h6042;
  localparam logic [15:0] I_STR = 16'h7042;
  localparam logic [15:0] I_NOT = 16'h907F;
  localparam logic [15:0] I_BR  = 16'h0E02;
  localparam logic [15:0] I_LEA = 16'hE000;
  localparam logic [15:0] I_RTI = 16'h8000;

  initial begin
    rst_n = 1'b0;
    cyc(1'b1, I_ADD, 1'b0, 2'd0, 4'b0000);
    cyc(1'b1, I_ADD, 1'b0, 2'd0, 4'b0000);
    check("rst_ready", 32'(instr_ready), 32'h0);
    check("rst_valid", 32'(stage_valid), 32'h0);
    check("rst_ctrl3", 32'(stage_ctrl[3]), 32'h0);
    check("rst_illegal", 32'(illegal_count), 32'h0);
    rst_n = 1'b1;
    #1;
    check("ready_idle", 32'(instr_ready), 32'h1);

    // ADD walks the pipe one stage per cycle
    cyc(1'b1, I_ADD, 1'b0, 2'd0, 4'b0000);
    check("add_valid", 32'(stage_valid), 32'b0001);
    check("add_word", 32'(stage_ctrl[0]), w(op_add, alu_add, 1, 0, 0, 0, 0));
    check("add_bubbles0", 32'(bubble_count), perf(0));
    cyc(1'b0, 16'h0, 1'b0, 2'd0, 4'b0000);
    check("add_s1", 32'(stage_valid), 32'b0010);
    cyc(1'b0, 16'h0, 1'b0, 2'd0, 4'b0000);
    cyc(1'b0, 16'h0, 1'b0, 2'd0, 4'b0000);
    check("add_s3_valid", 32'(stage_valid), 32'b1000);
    check("add_s3_word", 32'(stage_ctrl[3]), w(op_add, alu_add, 1, 0, 0, 0, 0));
    check("bubbles3", 32'(bubble_count), perf(3));
    cyc(1'b0, 16'h0, 1'b0, 2'd0, 4'b0000);
    check("drained", 32'(stage_valid), 32'h0);

    // stall with stall_stage=1 for two cycles
    cyc(1'b1, I_AND, 1'b0, 2'd0, 4'b0000);
    cyc(1'b1, I_LDR, 1'b0, 2'd0, 4'b0000);
    cyc(1'b1, I_STR, 1'b0, 2'd0, 4'b0000);
    check("stream_valid", 32'(stage_valid), 32'b0111);
    check("ldr_word", 32'(stage_ctrl[1]), w(op_ldr, alu_add, 1, 1, 0, 0, 0));
    instr_valid = 1'b1; instr = I_ADD; stall_en = 1'b1; stall_stage = 2'd1;
    #1;
    check("stall_ready", 32'(instr_ready), 32'h0);
    cyc(1'b1, I_ADD, 1'b1, 2'd1, 4'b0000);
    check("stall1_valid", 32'(stage_valid), 32'b1011);
    check("stall1_s3", 32'(stage_ctrl[3]), w(op_and, alu_and, 1, 0, 0, 0, 0));
    cyc(1'b1, I_ADD, 1'b1, 2'd1, 4'b0000);
    check("stall2_valid", 32'(stage_valid), 32'b0011);
    check("stall2_s2", 32'(stage_ctrl[2]), 32'h0);
    check("stall2_s0", 32'(stage_ctrl[0]), w(op_str, alu_add, 0, 0, 1, 0, 0));
    check("stall2_s1", 32'(stage_ctrl[1]), w(op_ldr, alu_add, 1, 1, 0, 0, 0));
    check("stall_cycles2", 32'(stall_cycles), perf(2));
    cyc(1'b0, 16'h0, 1'b0, 2'd0, 4'b0000);
    check("release_valid", 32'(stage_valid), 32'b0110);
    check("release_s1", 32'(stage_ctrl[1]), w(op_str, alu_add, 0, 0, 1, 0, 0));

    // flush stages 0 and 1 while accepting
    cyc(1'b1, I_ADD, 1'b0, 2'd0, 4'b0000);
    cyc(1'b1, I_AND, 1'b0, 2'd0, 4'b0000);
    cyc(1'b1, I_LDR, 1'b0, 2'd0, 4'b0000);
    cyc(1'b1, I_STR, 1'b0, 2'd0, 4'b0000);
    check("full_valid", 32'(stage_valid), 32'b1111);
    cyc(1'b1, I_NOT, 1'b0, 2'd0, 4'b0011);
    check("flush_valid", 32'(stage_valid), 32'b1001);
    check("flush_s0", 32'(stage_ctrl[0]), w(op_not, alu_not, 1, 0, 0, 0, 0));
    check("flush_s3", 32'(stage_ctrl[3]), w(op_and, alu_and, 1, 0, 0, 0, 0));

    // full-depth stall freezes the pipe
    bc_snap = 32'(bubble_count);
    sc_snap = 32'(stall_cycles);
    cyc(1'b1, I_ADD, 1'b1, 2'd3, 4'b0000);
    cyc(1'b1, I_ADD, 1'b1, 2'd3, 4'b0000);
    check("freeze_valid", 32'(stage_valid), 32'b1001);
    check("freeze_s0", 32'(stage_ctrl[0]), w(op_not, alu_not, 1, 0, 0, 0, 0));
    check("freeze_bubbles", 32'(bubble_count), bc_snap);
    check("freeze_stalls", 32'(stall_cycles), sc_snap + perf(2));
    cyc(1'b0, 16'h0, 1'b1, 2'd3, 4'b1000);
    check("stallflush_valid", 32'(stage_valid), 32'b0001);
    check("stallflush_s3", 32'(stage_ctrl[3]), w(op_and, alu_and, 1, 0, 0, 0, 0));

    // pass-through decodes
    cyc(1'b1, I_BR, 1'b0, 2'd0, 4'b0000);
    check("br_word", 32'(stage_ctrl[0]), w(op_br, alu_pass, 0, 0, 0, 1, 0));
    cyc(1'b1, I_LEA, 1'b0, 2'd0, 4'b0000);
    check("lea_word", 32'(stage_ctrl[0]), w(op_lea, alu_pass, 0, 0, 0, 0, 0));
    check("lea_s1_valid", 32'(stage_valid[1]), 32'h1);
    check("no_illegal", 32'(illegal_count), 32'h0);

    // illegal RTI counting and saturation
    cyc(1'b1, I_RTI, 1'b0, 2'd0, 4'b0000);
    check("rti_word", 32'(stage_ctrl[0]), w(op_rti, alu_add, 0, 0, 0, 0, 1));
    check("rti_valid", 32'(stage_valid[0]), 32'h1);
    cyc(1'b1, I_RTI, 1'b0, 2'd0, 4'b0000);
    cyc(1'b1, I_RTI, 1'b0, 2'd0, 4'b0000);
    check("illegal3", 32'(illegal_count), 32'd3);
    check("sat_illegal3", 32'(sat_illegal), 32'd3);
    cyc(1'b1, I_RTI, 1'b0, 2'd0, 4'b0000);
    check("illegal4", 32'(illegal_count), 32'd4);
    check("sat_hold", 32'(sat_illegal), 32'd3);

    // reset mid-stream
    rst_n = 1'b0; instr_valid = 1'b1; instr = I_RTI; stall_en = 1'b0; flush_mask = 4'b0000;
    #1;
    check("midrst_ready", 32'(instr_ready), 32'h0);
    cyc(1'b1, I_RTI, 1'b0, 2'd0, 4'b0000);
    check("midrst_valid", 32'(stage_valid), 32'h0);
    check("midrst_illegal", 32'(illegal_count), 32'h0);
    check("midrst_bubbles", 32'(bubble_count), 32'h0);
    check("midrst_stalls", 32'(stall_cycles), 32'h0);
    rst_n = 1'b1;
    cyc(1'b1, I_ADD, 1'b0, 2'd0, 4'b0000);
    check("post_valid", 32'(stage_valid), 32'b0001);
    check("post_word", 32'(stage_ctrl[0]), w(op_add, alu_add, 1, 0, 0, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
